// File: rtl/stepdir_counter.sv
// -----------------------------------------------------------------------------
// stepdir_counter
//   Step/dir input receiver. Both raw lines are synchronised (2 flops) and
//   glitch-filtered. Rising edges of the filtered step move a signed position
//   counter: down when dir is 1, up when dir is 0. The receiver also checks dir
//   setup/hold and the step high width against host-programmed minimums.
//
// Parameters
//   W     position counter width (two's complement, wraps)
//   T     width of dirtime/steptime and of the internal age counters
//   FILT  consecutive agreeing samples needed to accept a new level (>=1)
//
// Ports
//   clk               system clock
//   reset             synchronous, active-high reset
//   enable            count/check enable (sync, filter and FSM always run)
//   step_in, dir_in   raw asynchronous inputs
//   dirtime           min cycles dir must be stable before a step rising edge
//   steptime          min cycles step must stay high
//   latch             snapshot strobe for latched_position
//   clear_err         clears the sticky error flags
//   position          live count
//   latched_position  position captured on latch
//   err_setup         sticky dir-setup / dir-hold violation
//   err_width         sticky short step high pulse
//
// Optional feature: define STEPDIR_COUNTER_TIMESTAMP_EN to add a free-running
//   16-bit cycle counter, last_step_time (cycle of the latest counted step) and
//   latched_step_time (snapshot of last_step_time taken on latch).
// -----------------------------------------------------------------------------
module stepdir_counter #(
  parameter int W    = 16,
  parameter int T    = 5,
  parameter int FILT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         step_in,
  input  logic         dir_in,
  input  logic [T-1:0] dirtime,
  input  logic [T-1:0] steptime,
  input  logic         latch,
  input  logic         clear_err,
  output logic [W-1:0] position,
  output logic [W-1:0] latched_position,
  output logic         err_setup,
  output logic         err_width
`ifdef STEPDIR_COUNTER_TIMESTAMP_EN
  ,
  output logic [15:0]  last_step_time,
  output logic [15:0]  latched_step_time
`endif
);

  localparam int CW = $clog2(FILT + 1);

  typedef enum logic {S_LOW, S_HIGH} state_t;

  // Index 0 = step, index 1 = dir.
  logic [1:0]    sync0, sync1, filt, accept;
  logic [CW-1:0] fcnt [2];

  logic          step_f, dir_f, dir_prev, dir_chg;
  logic [T-1:0]  dir_age, high_cnt;
  state_t        state_q, state_d;
  logic          rise, fall, setup_viol, width_viol;

  assign step_f  = filt[0];
  assign dir_f   = filt[1];
  assign dir_chg = dir_f != dir_prev;

  // A new level is accepted on the FILT-th consecutive cycle it differs from
  // the current filtered level; any agreeing sample restarts the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      accept[i] = (sync1[i] != filt[i]) && (fcnt[i] == CW'(FILT - 1));
    end
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together from pre-edge values; blocking here would create order-
  // dependent races between the sync, filter and counter stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= '0;
      sync1 <= '0;
      filt  <= '0;
      // NOTE: the per-line filter counters form a tiny register array, not a
      // RAM, so resetting them is cheap and keeps the filter deterministic.
      fcnt  <= '{default: '0};
    end else begin
      sync0 <= {dir_in, step_in};
      sync1 <= sync0;
      for (int i = 0; i < 2; i++) begin
        if (sync1[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (accept[i]) begin
          fcnt[i] <= '0;
          filt[i] <= sync1[i];
        end else begin
          fcnt[i] <= fcnt[i] + CW'(1);
        end
      end
    end
  end

  // dir_age is 0 during the first cycle with the new filtered dir, so a dir
  // change in the same cycle as a step rise always reads as a zero setup time.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_prev <= 1'b0;
      dir_age  <= '0;
      high_cnt <= '0;
    end else begin
      dir_prev <= dir_f;
      if (accept[1])        dir_age <= '0;
      else if (dir_age != '1) dir_age <= dir_age + T'(1);
      if (!step_f)           high_cnt <= '0;
      else if (high_cnt != '1) high_cnt <= high_cnt + T'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOW;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    fall    = 1'b0;
    case (state_q)
      S_LOW:  if (step_f)  begin state_d = S_HIGH; rise = 1'b1; end
      S_HIGH: if (!step_f) begin state_d = S_LOW;  fall = 1'b1; end
      default: state_d = S_LOW;
    endcase
  end

  // A zero minimum can never be undercut, so dirtime/steptime = 0 disable
  // their checks without extra logic.
  always_comb begin
    setup_viol = enable && ((rise && (dir_age < dirtime)) ||
                            (state_q == S_HIGH && dir_chg));
    width_viol = enable && fall && (high_cnt < steptime);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      position         <= '0;
      latched_position <= '0;
      err_setup        <= 1'b0;
      err_width        <= 1'b0;
    end else begin
      if (enable && rise) begin
        position <= dir_f ? position - W'(1) : position + W'(1);
      end
      if (latch) latched_position <= position;
      // A violation in the same cycle as clear_err keeps the flag set.
      err_setup <= setup_viol | (err_setup & ~clear_err);
      err_width <= width_viol | (err_width & ~clear_err);
    end
  end

`ifdef STEPDIR_COUNTER_TIMESTAMP_EN
  logic [15:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt         <= '0;
      last_step_time    <= '0;
      latched_step_time <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 16'd1;
      if (enable && rise) last_step_time <= cycle_cnt;
      if (latch)          latched_step_time <= last_step_time;
    end
  end
`endif

endmodule

// File: tb/tb_stepdir_counter.sv
// -----------------------------------------------------------------------------
// tb_stepdir_counter
//   Bench for stepdir_counter (W=16 main instance plus a W=8 instance used
//   for the positive-overflow wrap). Expected results are queued when a
//   stimulus segment starts and popped for comparison once it has settled.
// -----------------------------------------------------------------------------
module tb_stepdir_counter;

  logic        clk = 1'b0;
  logic        reset, enable, step_in, dir_in, latch, clear_err;
  logic [4:0]  dirtime, steptime;
  logic [15:0] position, latched_position;
  logic        err_setup, err_width;
  logic [7:0]  position8, latched_position8;
  logic        err_setup8, err_width8;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [15:0] pos;
    logic [15:0] lat;
    logic        es;
    logic        ew;
  } exp_t;

  typedef struct {
    string       name;
    logic        en;
    logic        dir;
    int          n;
    int          hi;
    int          lo;
    logic        do_latch;
    logic [15:0] pos;
    logic [15:0] lat;
    logic        es;
    logic        ew;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];

  stepdir_counter #(.W(16), .T(5), .FILT(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step_in(step_in),
    .dir_in(dir_in), .dirtime(dirtime), .steptime(steptime), .latch(latch),
    .clear_err(clear_err), .position(position),
    .latched_position(latched_position), .err_setup(err_setup),
    .err_width(err_width)
  );

  stepdir_counter #(.W(8), .T(5), .FILT(2)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .step_in(step_in),
    .dir_in(dir_in), .dirtime(dirtime), .steptime(steptime), .latch(latch),
    .clear_err(clear_err), .position(position8),
    .latched_position(latched_position8), .err_setup(err_setup8),
    .err_width(err_width8)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    step_in = 1'b1;
    tick(hi);
    step_in = 1'b0;
    tick(lo);
  endtask

  task automatic clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
  endtask

  task automatic expect_out(input string name, input logic [15:0] pos,
                            input logic [15:0] lat, input logic es,
                            input logic ew);
    exp_t e;
    e.name = name; e.pos = pos; e.lat = lat; e.es = es; e.ew = ew;
    exp_q.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      check({e.name, "_pos"}, 32'(position), 32'(e.pos));
      check({e.name, "_lat"}, 32'(latched_position), 32'(e.lat));
      check({e.name, "_es"},  32'(err_setup), 32'(e.es));
      check({e.name, "_ew"},  32'(err_width), 32'(e.ew));
    end
  endtask

  initial begin
    //            name       en dir  n  hi lo latch pos      lat      es ew
    vecs[0] = '{"up9",      1, 0,   9, 8, 8, 0, 16'h000A, 16'h0000, 0, 0};
    vecs[1] = '{"down13",   1, 1,  13, 8, 8, 1, 16'hFFFD, 16'hFFFD, 0, 0};
    vecs[2] = '{"disabled", 0, 1,   5, 8, 8, 0, 16'hFFFD, 16'hFFFD, 0, 0};
    vecs[3] = '{"wrap0",    1, 0,   3, 8, 8, 0, 16'h0000, 16'hFFFD, 0, 0};
    vecs[4] = '{"hi4",      1, 0,   2, 4, 4, 0, 16'h0002, 16'hFFFD, 0, 0};

    reset = 1'b1; enable = 1'b1; step_in = 1'b0; dir_in = 1'b0;
    latch = 1'b0; clear_err = 1'b0; dirtime = 5'd3; steptime = 5'd4;

    tick(3);
    expect_out("reset", 16'h0, 16'h0, 1'b0, 1'b0);
    compare_pop();
    reset = 1'b0;
    tick(40);

    // First count lands on the 5th rising edge after step_in rises.
    step_in = 1'b1;
    tick(4);
    check("lat_edge4", 32'(position), 32'd0);
    tick(1);
    check("lat_edge5", 32'(position), 32'd1);
    tick(3);
    step_in = 1'b0;
    tick(8);

    for (int i = 0; i < 5; i++) begin
      enable = vecs[i].en;
      if (dir_in != vecs[i].dir) begin
        dir_in = vecs[i].dir;
        tick(8);
      end
      expect_out(vecs[i].name, vecs[i].pos, vecs[i].lat, vecs[i].es,
                 vecs[i].ew);
      repeat (vecs[i].n) pulse(vecs[i].hi, vecs[i].lo);
      tick(8);
      if (vecs[i].do_latch) begin
        latch = 1'b1;
        tick(1);
        latch = 1'b0;
        tick(1);
      end
      compare_pop();
    end
    enable = 1'b1;

    // Dir changes one cycle before step: setup violation, step still counted.
    dirtime = 5'd4;
    expect_out("setup", 16'h0001, 16'hFFFD, 1'b1, 1'b0);
    dir_in = 1'b1;
    tick(1);
    pulse(8, 8);
    compare_pop();
    expect_out("setup_clr", 16'h0001, 16'hFFFD, 1'b0, 1'b0);
    clear();
    compare_pop();

    // Dir changes while step is high: hold violation, setup check off.
    dirtime = 5'd0;
    expect_out("hold", 16'h0000, 16'hFFFD, 1'b1, 1'b0);
    step_in = 1'b1;
    tick(2);
    dir_in = 1'b0;
    tick(6);
    step_in = 1'b0;
    tick(8);
    compare_pop();
    clear();
    dirtime = 5'd3;

    // Short pulse: counted but flags width; 1-cycle glitch is dropped.
    expect_out("short", 16'h0001, 16'hFFFD, 1'b0, 1'b1);
    pulse(2, 8);
    compare_pop();
    clear();
    expect_out("glitch", 16'h0001, 16'hFFFD, 1'b0, 1'b0);
    pulse(1, 8);
    compare_pop();

    // Enable returning mid-high must not count until the next rising edge.
    enable = 1'b0;
    expect_out("en_mid", 16'h0001, 16'hFFFD, 1'b0, 1'b0);
    step_in = 1'b1;
    tick(8);
    enable = 1'b1;
    tick(4);
    step_in = 1'b0;
    tick(8);
    compare_pop();
    expect_out("en_next", 16'h0002, 16'hFFFD, 1'b0, 1'b0);
    pulse(8, 8);
    compare_pop();
    enable = 1'b0;
    expect_out("en0_short", 16'h0002, 16'hFFFD, 1'b0, 1'b0);
    pulse(2, 8);
    compare_pop();
    enable = 1'b1;

    // Wrap 0x7F -> 0x80 on the 8-bit instance, fast pulses.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    dirtime = 5'd0;
    steptime = 5'd2;
    tick(4);
    repeat (127) pulse(2, 2);
    tick(8);
    check("w8_7f", 32'(position8), 32'h7F);
    check("w16_7f", 32'(position), 32'h007F);
    pulse(2, 2);
    tick(8);
    check("w8_80", 32'(position8), 32'h80);
    check("w8_errs", 32'({err_setup8, err_width8}), 32'd0);
    expect_out("w16_80", 16'h0080, 16'h0000, 1'b0, 1'b0);
    compare_pop();

    // Latch, then reset mid-pulse; a still-high input counts as a new edge.
    latch = 1'b1;
    tick(1);
    latch = 1'b0;
    tick(1);
    check("latch80", 32'(latched_position), 32'h0080);
    step_in = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(2);
    expect_out("rst_mid", 16'h0000, 16'h0000, 1'b0, 1'b0);
    compare_pop();
    check("rst_mid8", 32'(position8), 32'h0);
    reset = 1'b0;
    tick(8);
    check("reaccept", 32'(position), 32'h0001);
    step_in = 1'b0;
    tick(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
